// File: rtl/fetch_unit_if.sv
// ---------------------------------------------------------------------------
// fetch_unit_if
// Bundle of the fetch stage's control, memory and decode-facing signals.
//   slave  modport : used by fetch_unit (consumes control, drives outputs)
//   master modport : used by the surrounding logic / bench
// Signals: fetch, fetchSrc[1:0], extend, stall, flush, branch, branchPc[AW],
//          imemData[16] (from memory), imemAddr[AW] (to memory),
//          instr[32], instrValid, pc[AW], busy.
// Optional: EPC_EN adds epc[AW] (address of interrupted instruction).
// ---------------------------------------------------------------------------
interface fetch_unit_if #(
  parameter int AW = 32
);
  logic          fetch;
  logic [1:0]    fetchSrc;
  logic          extend;
  logic          stall;
  logic          flush;
  logic          branch;
  logic [AW-1:0] branchPc;
  logic [15:0]   imemData;
  logic [AW-1:0] imemAddr;
  logic [31:0]   instr;
  logic          instrValid;
  logic [AW-1:0] pc;
  logic          busy;
`ifdef EPC_EN
  logic [AW-1:0] epc;

  modport slave (
    input  fetch, fetchSrc, extend, stall, flush, branch, branchPc, imemData,
    output imemAddr, instr, instrValid, pc, busy, epc
  );
  modport master (
    output fetch, fetchSrc, extend, stall, flush, branch, branchPc, imemData,
    input  imemAddr, instr, instrValid, pc, busy, epc
  );
`else
  modport slave (
    input  fetch, fetchSrc, extend, stall, flush, branch, branchPc, imemData,
    output imemAddr, instr, instrValid, pc, busy
  );
  modport master (
    output fetch, fetchSrc, extend, stall, flush, branch, branchPc, imemData,
    input  imemAddr, instr, instrValid, pc, busy
  );
`endif
endinterface

// File: rtl/fetch_unit.sv
// ---------------------------------------------------------------------------
// fetch_unit
// PC / instruction-fetch stage. Loads the fetch pointer from a reset or
// interrupt vector held in instruction memory, then fetches sequential
// 16/32-bit instructions (bit 15 of the first word marks a 32-bit one) from
// 16-bit-wide memory and presents them to decode with a valid flag.
// Ports:
//   clk  - rising-edge clock
//   rst  - asynchronous active-low reset
//   bus  - fetch_unit_if.slave (control inputs, memory port, decode outputs)
// Parameters: AW (address width), RST_VEC / INT_VEC (vector word addresses).
// Optional feature macro: EPC_EN (adds bus.epc, the exception return PC).
// ---------------------------------------------------------------------------
module fetch_unit #(
  parameter int          AW      = 32,
  parameter int unsigned RST_VEC = 32'd0,
  parameter int unsigned INT_VEC = 32'd2
) (
  input  logic          clk,
  input  logic          rst,
  fetch_unit_if.slave   bus
);

  typedef enum logic [1:0] {
    S_NORM = 2'd0,
    S_EXT  = 2'd1,
    S_VLO  = 2'd2,
    S_VHI  = 2'd3
  } state_e;

  localparam logic [AW-1:0] ONE = {{(AW-1){1'b0}}, 1'b1};

  state_e        state_q, state_d;
  logic [AW-1:0] ptr_q, ptr_d;
  logic [AW-1:0] pc_q, pc_d;
  logic [31:0]   instr_q, instr_d;
  logic          valid_q, valid_d;
  logic [15:0]   hi_q, hi_d;
  logic [15:0]   lo_q, lo_d;
  logic          vec_int_q, vec_int_d;
  logic          ext_q, ext_d;
  logic [AW-1:0] vec_base_s;
  logic [AW-1:0] addr_s;
`ifdef EPC_EN
  logic [AW-1:0] epc_q, epc_d;
`endif

  assign vec_base_s = vec_int_q ? AW'(INT_VEC) : AW'(RST_VEC);

  // Memory address: the pointer while fetching code, the vector slot while loading.
  always_comb begin
    addr_s = ptr_q;
    case (state_q)
      S_NORM:  addr_s = ptr_q;
      S_EXT:   addr_s = ptr_q;
      S_VLO:   addr_s = vec_base_s;
      S_VHI:   addr_s = vec_base_s + ONE;
      default: addr_s = ptr_q;
    endcase
  end

  // Next-state logic; priority fetch > branch > flush > stall > advance.
  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    pc_d      = pc_q;
    instr_d   = instr_q;
    valid_d   = valid_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    vec_int_d = vec_int_q;
    ext_d     = ext_q;
`ifdef EPC_EN
    epc_d     = epc_q;
`endif
    if (bus.fetch) begin
      vec_int_d = (bus.fetchSrc == 2'b01);
      ext_d     = bus.extend;
      state_d   = S_VLO;
      valid_d   = 1'b0;
`ifdef EPC_EN
      // In EXT the pointer already moved past the half-fetched first word.
      if (bus.fetchSrc == 2'b01) begin
        epc_d = (state_q == S_EXT) ? (ptr_q - ONE) : ptr_q;
      end else begin
        epc_d = epc_q;
      end
`endif
    end else if (bus.branch) begin
      ptr_d   = bus.branchPc;
      state_d = S_NORM;
      valid_d = 1'b0;
    end else if (bus.flush) begin
      valid_d = 1'b0;
      // Drop the partial 32-bit instruction and refetch its first word.
      if (state_q == S_EXT) begin
        ptr_d   = ptr_q - ONE;
        state_d = S_NORM;
      end else begin
        ptr_d   = ptr_q;
      end
    end else if (bus.stall) begin
      state_d = state_q;
    end else begin
      case (state_q)
        S_NORM: begin
          ptr_d = ptr_q + ONE;
          if (bus.imemData[15]) begin
            hi_d    = bus.imemData;
            state_d = S_EXT;
            valid_d = 1'b0;
          end else begin
            instr_d = {16'h0000, bus.imemData};
            pc_d    = ptr_q;
            valid_d = 1'b1;
          end
        end
        S_EXT: begin
          instr_d = {hi_q, bus.imemData};
          pc_d    = ptr_q - ONE;
          valid_d = 1'b1;
          ptr_d   = ptr_q + ONE;
          state_d = S_NORM;
        end
        S_VLO: begin
          valid_d = 1'b0;
          if (ext_q) begin
            lo_d    = bus.imemData;
            state_d = S_VHI;
          end else begin
            ptr_d   = AW'(bus.imemData);
            state_d = S_NORM;
          end
        end
        S_VHI: begin
          valid_d = 1'b0;
          ptr_d   = AW'({bus.imemData, lo_q});
          state_d = S_NORM;
        end
        default: begin
          state_d = S_NORM;
          valid_d = 1'b0;
        end
      endcase
    end
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= S_NORM;
      ptr_q     <= {AW{1'b0}};
      pc_q      <= {AW{1'b0}};
      instr_q   <= 32'h0000_0000;
      valid_q   <= 1'b0;
      hi_q      <= 16'h0000;
      lo_q      <= 16'h0000;
      vec_int_q <= 1'b0;
      ext_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      pc_q      <= pc_d;
      instr_q   <= instr_d;
      valid_q   <= valid_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      vec_int_q <= vec_int_d;
      ext_q     <= ext_d;
    end
  end

`ifdef EPC_EN
  // Exception return address register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      epc_q <= {AW{1'b0}};
    end else begin
      epc_q <= epc_d;
    end
  end

  assign bus.epc = epc_q;
`endif

  assign bus.imemAddr   = addr_s;
  assign bus.instr      = instr_q;
  assign bus.instrValid = valid_q;
  assign bus.pc         = pc_q;
  assign bus.busy       = (state_q == S_VLO) || (state_q == S_VHI);

endmodule

// File: tb/tb_fetch_unit.sv
// ---------------------------------------------------------------------------
// tb_fetch_unit
// Self-checking bench for fetch_unit: directed scenarios with literal
// expectations, then randomized control traffic. A behavioural model tracks
// the fetch pointer, a pending-half flag and a vector-load step count; a
// negedge process compares every output against it each cycle.
// ---------------------------------------------------------------------------
module tb_fetch_unit;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_errors;

  logic [15:0] mem_a [0:1023];

  fetch_unit_if #(.AW(32)) bus ();

  fetch_unit #(.AW(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  assign bus.imemData = mem_a[bus.imemAddr[9:0]];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural model state
  logic [31:0] m_ptr, m_first, m_instr, m_pc, m_epc;
  logic [15:0] m_hi, m_lo;
  logic        m_valid, m_half, m_vec_int, m_vec_two;
  int          m_step;   // 0 = fetching code, 1 = vector low word, 2 = vector high word

  function automatic logic [15:0] rd(input logic [31:0] a);
    return mem_a[a[9:0]];
  endfunction

  function automatic logic [31:0] exp_addr();
    logic [31:0] base;
    base = m_vec_int ? 32'd2 : 32'd0;
    if (m_step == 1) return base;
    if (m_step == 2) return base + 32'd1;
    return m_ptr;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_ptr = 32'd0; m_first = 32'd0; m_instr = 32'd0; m_pc = 32'd0; m_epc = 32'd0;
    m_hi = 16'd0; m_lo = 16'd0; m_valid = 1'b0; m_half = 1'b0;
    m_vec_int = 1'b0; m_vec_two = 1'b0; m_step = 0;
  endtask

  task automatic model_step();
    logic [15:0] d;
    logic [31:0] base;
    base = m_vec_int ? 32'd2 : 32'd0;
    if (bus.fetch) begin
      if (bus.fetchSrc == 2'b01) m_epc = m_half ? m_first : m_ptr;
      m_vec_int = (bus.fetchSrc == 2'b01);
      m_vec_two = bus.extend;
      m_step = 1; m_half = 1'b0; m_valid = 1'b0;
    end else if (bus.branch) begin
      m_ptr = bus.branchPc; m_step = 0; m_half = 1'b0; m_valid = 1'b0;
    end else if (bus.flush) begin
      m_valid = 1'b0;
      if (m_half) begin m_ptr = m_first; m_half = 1'b0; end
    end else if (bus.stall) begin
      // everything holds
    end else if (m_step == 1) begin
      d = rd(base);
      if (m_vec_two) begin m_lo = d; m_step = 2; end
      else begin m_ptr = {16'h0000, d}; m_step = 0; end
    end else if (m_step == 2) begin
      m_ptr = {rd(base + 32'd1), m_lo}; m_step = 0;
    end else if (m_half) begin
      m_instr = {m_hi, rd(m_ptr)}; m_pc = m_first; m_valid = 1'b1;
      m_ptr = m_ptr + 32'd1; m_half = 1'b0;
    end else begin
      d = rd(m_ptr);
      if (d[15]) begin
        m_hi = d; m_first = m_ptr; m_half = 1'b1; m_valid = 1'b0;
      end else begin
        m_instr = {16'h0000, d}; m_pc = m_ptr; m_valid = 1'b1;
      end
      m_ptr = m_ptr + 32'd1;
    end
  endtask

  // One clock: DUT and model advance on the rising edge, inputs change at the falling edge.
  task automatic step();
    @(posedge clk);
    if (rst) model_step();
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    bus.fetch = 1'b0; bus.fetchSrc = 2'b00; bus.extend = 1'b0; bus.stall = 1'b0;
    bus.flush = 1'b0; bus.branch = 1'b0; bus.branchPc = 32'd0;
  endtask

  // Compare process: every output against the model on each falling edge.
  always @(negedge clk) begin
    chk("imemAddr",   bus.imemAddr, exp_addr());
    chk("busy",       {31'd0, bus.busy}, {31'd0, (m_step != 0)});
    chk("instrValid", {31'd0, bus.instrValid}, {31'd0, m_valid});
    chk("instr",      bus.instr, m_instr);
    chk("pc",         bus.pc, m_pc);
`ifdef EPC_EN
    chk("epc",        bus.epc, m_epc);
`endif
  end

  initial begin
    n_checks = 0;
    n_errors = 0;
    for (int i = 0; i < 1024; i++) mem_a[i] = 16'($urandom);
    mem_a[0]     = 16'h0040; mem_a[1]     = 16'h0000;
    mem_a[2]     = 16'h0200; mem_a[3]     = 16'h0001;
    mem_a[10'h040] = 16'h1234; mem_a[10'h041] = 16'h8001;
    mem_a[10'h042] = 16'hABCD; mem_a[10'h043] = 16'h0043;
    mem_a[10'h044] = 16'h0044; mem_a[10'h100] = 16'h0100;
    mem_a[10'h3FF] = 16'h0777;

    rst = 1'b0;
    idle_inputs();
    model_reset();
    repeat (3) @(negedge clk);
    chk("reset_valid", {31'd0, bus.instrValid}, 32'd0);
    chk("reset_addr",  bus.imemAddr, 32'd0);
    rst = 1'b1;

    // Reset vector, two words
    bus.fetch = 1'b1; bus.fetchSrc = 2'b00; bus.extend = 1'b1;
    step();
    idle_inputs();
    chk("rv_busy_lo", {31'd0, bus.busy}, 32'd1);
    chk("rv_addr_lo", bus.imemAddr, 32'd0);
    step();
    chk("rv_busy_hi", {31'd0, bus.busy}, 32'd1);
    chk("rv_addr_hi", bus.imemAddr, 32'd1);
    step();
    chk("rv_busy_done", {31'd0, bus.busy}, 32'd0);
    chk("rv_ptr", bus.imemAddr, 32'h0000_0040);
    step();
    chk("mix_i16", bus.instr, 32'h0000_1234);
    chk("mix_pc16", bus.pc, 32'h0000_0040);
    chk("mix_v16", {31'd0, bus.instrValid}, 32'd1);
    step();
    chk("mix_bubble", {31'd0, bus.instrValid}, 32'd0);
    step();
    chk("mix_i32", bus.instr, 32'h8001_ABCD);
    chk("mix_pc32", bus.pc, 32'h0000_0041);

    // Stall mid-stream
    step();
    bus.stall = 1'b1;
    repeat (3) step();
    chk("stall_instr", bus.instr, 32'h0000_0043);
    chk("stall_addr", bus.imemAddr, 32'h0000_0044);
    bus.stall = 1'b0;
    step();
    chk("stall_next_pc", bus.pc, 32'h0000_0044);

    // Interrupt vector while stalled in EXT at ptr 0x42
    bus.branch = 1'b1; bus.branchPc = 32'h0000_0041;
    step();
    idle_inputs();
    step();
    chk("int_ext_addr", bus.imemAddr, 32'h0000_0042);
    bus.fetch = 1'b1; bus.fetchSrc = 2'b01; bus.extend = 1'b1; bus.stall = 1'b1;
    step();
    idle_inputs();
    chk("int_addr_lo", bus.imemAddr, 32'd2);
    step();
    chk("int_addr_hi", bus.imemAddr, 32'd3);
    step();
    chk("int_ptr", bus.imemAddr, 32'h0001_0200);
`ifdef EPC_EN
    chk("int_epc", bus.epc, 32'h0000_0041);
`endif

    // Branch while in EXT
    bus.branch = 1'b1; bus.branchPc = 32'h0000_0041;
    step();
    idle_inputs();
    step();
    bus.branch = 1'b1; bus.branchPc = 32'h0000_0100;
    step();
    idle_inputs();
    chk("br_addr", bus.imemAddr, 32'h0000_0100);
    step();
    chk("br_pc", bus.pc, 32'h0000_0100);
    chk("br_instr", bus.instr, 32'h0000_0100);

    // Flush while in EXT refetches from the first word
    bus.branch = 1'b1; bus.branchPc = 32'h0000_0041;
    step();
    idle_inputs();
    step();
    bus.flush = 1'b1;
    step();
    idle_inputs();
    chk("fl_addr", bus.imemAddr, 32'h0000_0041);
    chk("fl_valid", {31'd0, bus.instrValid}, 32'd0);
    step();
    step();
    chk("fl_instr", bus.instr, 32'h8001_ABCD);
    chk("fl_pc", bus.pc, 32'h0000_0041);

    // Pointer wrap at all-ones
    bus.branch = 1'b1; bus.branchPc = 32'hFFFF_FFFF;
    step();
    idle_inputs();
    step();
    chk("wrap_pc", bus.pc, 32'hFFFF_FFFF);
    chk("wrap_instr", bus.instr, 32'h0000_0777);
    chk("wrap_addr", bus.imemAddr, 32'h0000_0000);

    // Randomized control traffic
    for (int c = 0; c < 3000; c++) begin
      bus.fetch    = ($urandom_range(99) < 3);
      bus.fetchSrc = 2'($urandom);
      bus.extend   = 1'($urandom);
      bus.branch   = ($urandom_range(99) < 5);
      bus.branchPc = $urandom;
      bus.flush    = ($urandom_range(99) < 5);
      bus.stall    = ($urandom_range(99) < 15);
      step();
    end
    idle_inputs();
    step();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
PC and instruction-fetch stage directly downstream of fetch control. It consumes fetch, fetchSrc and extend. On a vector request it reads a handler address from instruction memory and loads the fetch pointer with it. Otherwise it fetches sequential 16/32-bit instructions from 16-bit-wide instruction memory and presents them to decode with a valid flag.

Parameters:
AW, 32, fetch pointer / PC / memory address width (word-addressed, 16-bit words)
RST_VEC, 0, word address of the low half of the reset vector
INT_VEC, 2, word address of the low half of the interrupt vector

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous active-low reset
fetch  in  1  vector load request from fetch control
fetchSrc  in  2  vector select: 00 = reset, 01 = interrupt, others treated as reset
extend  in  1  sampled with fetch: 1 = two-word vector, 0 = single-word vector (zero-extended)
stall  in  1  freeze stage
flush  in  1  squash output and any partial instruction
branch  in  1  redirect fetch pointer to branchPc
branchPc  in  AW  redirect target
imemData  in  16  instruction memory read data, combinational from imemAddr
imemAddr  out  AW  instruction memory word address (combinational from state)
instr  out  32  fetched instruction; 16-bit instructions zero-extended
instrValid  out  1  instr/pc valid for decode
pc  out  AW  word address of first word of instr
busy  out  1  vector load in progress

Behaviour:
- Reset (async, rst=0): ptr=0, state=NORM, instr=0, pc=0, instrValid=0, hi=0, lo=0.
- States:
  - NORM: fetch first/only word.
  - EXT: fetch second word of a 32-bit instruction.
  - VLO: read vector low word.
  - VHI: read vector high word.
- busy=1 in VLO/VHI, else 0.
- imemAddr:
  - NORM/EXT: ptr.
  - VLO: vecBase.
  - VHI: vecBase+1.
  - vecBase = INT_VEC if fetchSrc==01 (latched at fetch), else RST_VEC.
- Per-edge priority: fetch > branch > flush > stall > normal advance.
- fetch=1 (any state, stall ignored):
  - Latch vecBase and extend; state<=VLO; instrValid<=0; partial EXT discarded.
- VLO:
  - extend=1: lo<=imemData; state<=VHI.
  - extend=0: ptr<=zero-extended imemData; state<=NORM.
- VHI: ptr<={imemData, lo}; state<=NORM.
- branch=1 (not fetch): ptr<=branchPc; state<=NORM; instrValid<=0. Overrides an in-progress vector load.
- flush=1 alone: instrValid<=0. If in EXT: ptr<=ptr-1 (restart at first word), state<=NORM.
- stall=1 alone: ptr, state, instr, pc, instrValid, hi all hold; imemAddr stable.
- NORM advance:
  - imemData[15]=0: instr<={16'h0, imemData}, pc<=ptr, instrValid<=1, ptr<=ptr+1.
  - imemData[15]=1: hi<=imemData, ptr<=ptr+1, state<=EXT, instrValid<=0.
- EXT advance: instr<={hi, imemData}, pc<=ptr-1, instrValid<=1, ptr<=ptr+1, state<=NORM.
- Latency: instruction registered 1 cycle after last word read. A 32-bit instruction costs 2 cycles, with a one-cycle instrValid=0 bubble.
- Arithmetic: ptr/pc increments and decrements wrap modulo 2^AW. A 32-bit instruction whose first word is at all-ones takes its second word from 0.
- instrValid never asserts during VLO/VHI.

Optional Feature:
EPC_EN
- Defined:
  - Adds output epc (AW wide), reset 0.
  - On an accepted fetch with fetchSrc==01: epc<=address of the oldest unissued instruction (ptr in NORM, ptr-1 in EXT), captured regardless of stall.
  - epc is unchanged by reset-vector fetches.
- Undefined: port and register absent; behaviour otherwise identical.

Test Plan:
- Reset vector: release rst; fetch=1, fetchSrc=00, extend=1; mem[0]=0x0040, mem[1]=0x0000 -> busy=1 for 2 cycles, then imemAddr=0x40; next cycle instrValid=1, pc=0x40.
- Mixed lengths: mem[0x40]=0x1234, [0x41]=0x8001, [0x42]=0xABCD -> instr=0x00001234 (pc=0x40); one bubble; then instr=0x8001ABCD (pc=0x41).
- Stall: stall=1 for 3 cycles mid-stream -> instr, pc, instrValid, imemAddr constant; no word skipped or repeated after release.
- Branch in EXT: branch=1, branchPc=0x100 while in EXT -> partial discarded; next valid instr has pc=0x100. Flush alone in EXT -> refetch of the 32-bit instruction from its first word.
- Interrupt: fetch=1, fetchSrc=01, stall=1 while in EXT at ptr=0x42; mem[2]=0x0200, mem[3]=0x0001 -> imemAddr 2 then 3, ptr=0x00010200. With EPC_EN: epc=0x41.
- Wrap: 16-bit instruction at ptr=0xFFFFFFFF -> pc=0xFFFFFFFF, next imemAddr=0x00000000.
